execute_stage: RTL

- Execute stage directly downstream of the decode pipeline register.
- Consumes the registered opcode, operands, immediate, destination and write-enable, and performs the ALU operation.
- Latches the result into an execute/writeback register.
- Adds a valid/ready handshake so a multi-cycle multiply can stall the decode register.

---
 rtl/execute_stage_if.sv | 18 +
 rtl/execute_stage.sv | 107 ++++++++++
 2 files changed

// File: rtl/execute_stage_if.sv
// execute_stage_if: decode-to-execute handshake plus registered execute/writeback outputs
// Ports: in_valid/in_ready handshake, alu_opcode, reg_flag, op1, op2, data, rd, reg_wr_en
//        from decode; out_valid, result, rd_out, wr_en_out toward writeback.
// master = decode/testbench side, slave = execute_stage.
interface execute_stage_if #(parameter int XLEN = 32, parameter int RD_W = 5);
  logic in_valid, in_ready, reg_flag, reg_wr_en, out_valid, wr_en_out;
  logic [3:0] alu_opcode;
  logic [XLEN-1:0] op1, op2, data, result;
  logic [RD_W-1:0] rd, rd_out;
  modport master (
    output in_valid, alu_opcode, reg_flag, op1, op2, data, rd, reg_wr_en,
    input  in_ready, out_valid, result, rd_out, wr_en_out
  );
  modport slave (
    input  in_valid, alu_opcode, reg_flag, op1, op2, data, rd, reg_wr_en,
    output in_ready, out_valid, result, rd_out, wr_en_out
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: ALU execute stage with execute/writeback register and optional multi-cycle MUL
// Ports: clk, rst (sync, active-high), bus (execute_stage_if.slave: decode handshake in,
//        registered result/rd_out/wr_en_out with a one-cycle out_valid pulse out).
// Macro EXEC_MUL_EN: when defined, opcode 11 is a shift-add multiply taking XLEN cycles
// that stalls decode through in_ready; when undefined opcode 11 is reserved.
module execute_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input logic clk,
  input logic rst,
  execute_stage_if.slave bus
);
  logic [XLEN-1:0] b, alu_res;
  logic [4:0] sh;
  logic acc_in, is_mul, wr_ok, op_ok;
  assign b = bus.reg_flag ? bus.data : bus.op2;
  assign sh = b[4:0];
  assign acc_in = bus.in_valid & bus.in_ready;
  assign wr_ok = bus.reg_wr_en & (bus.rd != '0);
  assign op_ok = bus.alu_opcode <= 4'd10;
  always_comb begin
    alu_res = '0;
    case (bus.alu_opcode)
      4'd0:    alu_res = bus.op1 + b;
      4'd1:    alu_res = bus.op1 - b;
      4'd2:    alu_res = bus.op1 & b;
      4'd3:    alu_res = bus.op1 | b;
      4'd4:    alu_res = bus.op1 ^ b;
      4'd5:    alu_res = bus.op1 << sh;
      4'd6:    alu_res = bus.op1 >> sh;
      4'd7:    alu_res = $unsigned($signed(bus.op1) >>> sh);
      4'd8:    alu_res = XLEN'($signed(bus.op1) < $signed(b));
      4'd9:    alu_res = XLEN'(bus.op1 < b);
      4'd10:   alu_res = b;
      default: alu_res = '0;
    endcase
  end
`ifdef EXEC_MUL_EN
  typedef enum logic {IDLE, MUL_BUSY} state_t;
  localparam int CW = $clog2(XLEN);
  state_t state, state_n;
  logic [XLEN-1:0] mcand, mplier, acc, acc_n;
  logic [CW-1:0] cnt;
  logic [RD_W-1:0] mul_rd;
  logic mul_wr, mul_done;
  assign is_mul = bus.alu_opcode == 4'd11;
  assign bus.in_ready = state == IDLE;
  assign acc_n = acc + (mplier[0] ? mcand : '0);
  assign mul_done = (state == MUL_BUSY) && (cnt == CW'(XLEN - 1));
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? ((acc_in && is_mul) ? MUL_BUSY : IDLE)
                              : (mul_done ? IDLE : MUL_BUSY);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      mul_rd <= '0;
      mul_wr <= 1'b0;
    end else if (acc_in && is_mul) begin
      mcand  <= bus.op1;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      mul_rd <= bus.rd;
      mul_wr <= wr_ok;
    end else if (state == MUL_BUSY) begin
      acc    <= acc_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end
`else
  assign is_mul = 1'b0;
  assign bus.in_ready = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result    <= '0;
      bus.rd_out    <= '0;
      bus.wr_en_out <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (acc_in && !is_mul) begin
        bus.result    <= alu_res;
        bus.rd_out    <= bus.rd;
        bus.wr_en_out <= wr_ok & op_ok;
        bus.out_valid <= 1'b1;
      end
`ifdef EXEC_MUL_EN
      else if (mul_done) begin
        bus.result    <= acc_n;
        bus.rd_out    <= mul_rd;
        bus.wr_en_out <= mul_wr;
        bus.out_valid <= 1'b1;
      end
`endif
    end
  end
endmodule
